// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C write master among N requesters.
// Grants, latches payload, launches the master and acknowledges completion or timeout.
module i2c_req_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_s_addr,
  input  logic [8*N-1:0] req_r_addr,
  input  logic [8*N-1:0] req_data,
  input  logic           m_busy,
  output logic           m_start,
  output logic [7:0]     m_s_addr,
  output logic [7:0]     m_r_addr,
  output logic [7:0]     m_data,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   err,
  output logic           arb_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(N);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          efl_q, efl_d;
  logic          start_q, start_d;
  logic [7:0]    s_q, s_d;
  logic [7:0]    r_q, r_d;
  logic [7:0]    d_q, d_d;

  logic          hit;
  int            sel;
  int            j;

  // first set request searching upward from the pointer, wrapping
  always_comb begin
    hit = 1'b0;
    sel = 0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!hit && req[j]) begin
        hit = 1'b1;
        sel = j;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    efl_d   = efl_q;
    start_d = start_q;
    s_d     = s_q;
    r_d     = r_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d    = LAUNCH;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          s_d        = req_s_addr[8*sel +: 8];
          r_d        = req_r_addr[8*sel +: 8];
          d_d        = req_data[8*sel +: 8];
          start_d    = 1'b1;
          cnt_d      = '0;
          ptr_d      = PW'((sel + 1) % N);
        end
      end
      LAUNCH: begin
        if (m_busy) begin
          state_d = RUN;
          start_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == TLAST) begin
          state_d = DONE;
          start_d = 1'b0;
          efl_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!m_busy) begin
          state_d = DONE;
        end else if (cnt_q == TLAST) begin
          state_d = DONE;
          efl_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        efl_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      efl_q   <= 1'b0;
      start_q <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      efl_q   <= efl_d;
      start_q <= start_d;
      s_q     <= s_d;
      r_q     <= r_d;
      d_q     <= d_d;
    end
  end

  assign m_start  = start_q;
  assign m_s_addr = s_q;
  assign m_r_addr = r_q;
  assign m_data   = d_q;
  assign gnt      = gnt_q;
  assign ack      = (state_q == DONE) ? gnt_q : '0;
  assign err      = ack & {N{efl_q}};
  assign arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized bench for i2c_req_arbiter against a transaction-level timing model.
// Ends with a directed asynchronous reset in mid-transaction.
module tb_i2c_req_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_s_addr;
  logic [8*N-1:0] req_r_addr;
  logic [8*N-1:0] req_data;
  logic           m_busy;
  logic           m_start;
  logic [7:0]     m_s_addr;
  logic [7:0]     m_r_addr;
  logic [7:0]     m_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic           arb_busy;

  i2c_req_arbiter #(.N(N), .TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_s_addr (req_s_addr),
    .req_r_addr (req_r_addr),
    .req_data   (req_data),
    .m_busy     (m_busy),
    .m_start    (m_start),
    .m_s_addr   (m_s_addr),
    .m_r_addr   (m_r_addr),
    .m_data     (m_data),
    .gnt        (gnt),
    .ack        (ack),
    .err        (err),
    .arb_busy   (arb_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int   t = 0;
  int   g = 0;
  int   lat = 0;
  int   blen = 0;
  int   done_at = 0;
  int   gidx = 0;
  int   ptr = 0;
  bit   act = 1'b0;
  bit   err_x = 1'b0;
  logic [7:0] xs = '0;
  logic [7:0] xr = '0;
  logic [7:0] xd = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // One cycle: update the model, compare, then drive inputs for the next edge.
  task automatic step(input bit rnd);
    bit           act_last;
    bit           hit;
    bit           is_ack;
    logic [N-1:0] oh;
    t++;
    act_last = act;
    if (act && t > done_at) act = 1'b0;
    if (!act_last && req != '0) begin
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        int jj;
        jj = (ptr + k) % N;
        if (!hit && req[jj]) begin
          hit  = 1'b1;
          gidx = jj;
        end
      end
      ptr  = (gidx + 1) % N;
      act  = 1'b1;
      g    = t;
      xs   = req_s_addr[8*gidx +: 8];
      xr   = req_r_addr[8*gidx +: 8];
      xd   = req_data[8*gidx +: 8];
      lat  = ($urandom_range(5) == 0) ? 1000 : int'($urandom_range(5));
      blen = ($urandom_range(5) == 0) ? T + 1 + int'($urandom_range(3))
                                      : 1 + int'($urandom_range(11));
      if (lat >= T) begin
        done_at = g + T;
        err_x   = 1'b1;
      end else if (blen > T) begin
        done_at = g + lat + 1 + T;
        err_x   = 1'b1;
      end else begin
        done_at = g + lat + blen + 1;
        err_x   = 1'b0;
      end
    end
    oh = '0;
    if (act) oh[gidx] = 1'b1;
    is_ack = act && (t == done_at);
    chk("gnt", 32'(gnt), 32'(oh));
    chk("arb_busy", 32'(arb_busy), 32'(act));
    chk("m_start", 32'(m_start),
        32'(act && t <= g + ((lat < T - 1) ? lat : T - 1)));
    chk("m_s_addr", 32'(m_s_addr), 32'(xs));
    chk("m_r_addr", 32'(m_r_addr), 32'(xr));
    chk("m_data", 32'(m_data), 32'(xd));
    chk("ack", 32'(ack), is_ack ? 32'(oh) : 32'd0);
    chk("err", 32'(err), (is_ack && err_x) ? 32'(oh) : 32'd0);

    if (is_ack) req[gidx] = 1'b0;
    m_busy = act && lat < T && t >= g + lat && t < g + lat + blen &&
             t < done_at;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !(is_ack && i == gidx) && $urandom_range(3) == 0) begin
          req[i]             = 1'b1;
          req_s_addr[8*i +: 8] = 8'($urandom);
          req_r_addr[8*i +: 8] = 8'($urandom);
          req_data[8*i +: 8]   = 8'($urandom);
        end else if ($urandom_range(7) == 0) begin
          req_data[8*i +: 8]   = 8'($urandom);
          req_s_addr[8*i +: 8] = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    req        = '0;
    req_s_addr = '0;
    req_r_addr = '0;
    req_data   = '0;
    m_busy     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      step(1'b1);
    end
    for (int c = 0; c < 600 && (act || req != '0); c++) begin
      @(negedge clk);
      step(1'b0);
    end
    chk("drain", {31'd0, act || req != '0}, 32'd0);

    // mid-RUN asynchronous reset, then pointer restart
    @(negedge clk);
    req                = 4'b0010;
    req_s_addr[15:8]   = 8'h3C;
    req_r_addr[15:8]   = 8'h21;
    req_data[15:8]     = 8'h77;
    @(negedge clk);
    chk("rr_gnt_pre", 32'(gnt), 32'h2);
    chk("rr_data_pre", 32'(m_data), 32'h77);
    m_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rr_busy_pre", 32'(arb_busy), 32'd1);
    chk("rr_start_pre", 32'(m_start), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_start", 32'(m_start), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_saddr", 32'(m_s_addr), 32'd0);
    m_busy = 1'b0;
    req    = '0;
    @(negedge clk);
    chk("rst_ack2", 32'(ack), 32'd0);
    rst = 1'b1;
    req = 4'b1001;
    @(negedge clk);
    chk("post_gnt", 32'(gnt), 32'h1);
    chk("post_start", 32'(m_start), 32'd1);
    chk("post_saddr", 32'(m_s_addr), 32'(req_s_addr[7:0]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
